// File: rtl/max7219_spi_serializer.sv
// Shifts G_MATRIX_NB 16-bit words MSB first onto the MAX7219 CLK/DIN pins and closes the frame with a LOAD pulse.
// Per word: 1 handshake cycle + 32*G_MAX_HALF_PERIOD shift cycles; o_data_ready only in WAIT_WORD, so upstream stalls simply stretch WAIT_WORD.
module max7219_spi_serializer #(
   parameter int G_MATRIX_NB       = 8,
   parameter int G_MAX_HALF_PERIOD = 4,
   parameter int G_LOAD_DURATION   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [15:0] i_data,
   input  logic        i_data_valid,
   output logic        o_data_ready,
   output logic        o_max7219_clk,
   output logic        o_max7219_data,
   output logic        o_max7219_load,
   output logic        o_busy,
   output logic        o_frame_done
);

   localparam int CNT_MAX = (G_MAX_HALF_PERIOD > G_LOAD_DURATION) ? G_MAX_HALF_PERIOD : G_LOAD_DURATION;
   localparam int PW      = $clog2(CNT_MAX) + 1;
   localparam int WW      = $clog2(G_MATRIX_NB) + 1;

   localparam logic [PW-1:0] HALF_LAST = PW'(G_MAX_HALF_PERIOD - 1);
   localparam logic [PW-1:0] LOAD_LAST = PW'(G_LOAD_DURATION - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(G_MATRIX_NB - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_WORD,
      S_CLK_LOW,
      S_CLK_HIGH,
      S_LOAD
   } state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] phase_cnt, phase_nxt;
   logic [3:0]    bit_cnt, bit_nxt;
   logic [WW-1:0] word_cnt, word_nxt;
   logic [14:0]   shift_reg, shift_nxt;
   logic          din_nxt;

   always_comb begin
      state_nxt = state;
      phase_nxt = phase_cnt;
      bit_nxt   = bit_cnt;
      word_nxt  = word_cnt;
      shift_nxt = shift_reg;
      din_nxt   = o_max7219_data;

      case (state)
         S_IDLE: begin
            // o_frame_done marks the first IDLE cycle; a start there is dropped
            if (i_start && !o_frame_done) begin
               state_nxt = S_WAIT_WORD;
               word_nxt  = '0;
            end
         end

         S_WAIT_WORD: begin
            if (i_data_valid && o_data_ready) begin
               shift_nxt = i_data[14:0];
               bit_nxt   = 4'd15;
               din_nxt   = i_data[15];
               phase_nxt = '0;
               state_nxt = S_CLK_LOW;
            end
         end

         S_CLK_LOW: begin
            if (phase_cnt == HALF_LAST) begin
               phase_nxt = '0;
               state_nxt = S_CLK_HIGH;
            end else begin
               phase_nxt = phase_cnt + PW'(1);
            end
         end

         S_CLK_HIGH: begin
            if (phase_cnt == HALF_LAST) begin
               phase_nxt = '0;
               // DIN only moves here, together with the CLK fall
               if (bit_cnt != 4'd0) begin
                  bit_nxt   = bit_cnt - 4'd1;
                  din_nxt   = shift_reg[14];
                  shift_nxt = {shift_reg[13:0], 1'b0};
                  state_nxt = S_CLK_LOW;
               end else if (word_cnt != WORD_LAST) begin
                  word_nxt  = word_cnt + WW'(1);
                  state_nxt = S_WAIT_WORD;
               end else begin
                  state_nxt = S_LOAD;
               end
            end else begin
               phase_nxt = phase_cnt + PW'(1);
            end
         end

         S_LOAD: begin
            if (phase_cnt == LOAD_LAST) begin
               phase_nxt = '0;
               state_nxt = S_IDLE;
            end else begin
               phase_nxt = phase_cnt + PW'(1);
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         phase_cnt      <= '0;
         bit_cnt        <= '0;
         word_cnt       <= '0;
         shift_reg      <= '0;
         o_data_ready   <= 1'b0;
         o_max7219_clk  <= 1'b0;
         o_max7219_data <= 1'b0;
         o_max7219_load <= 1'b0;
         o_busy         <= 1'b0;
         o_frame_done   <= 1'b0;
      end else begin
         state          <= state_nxt;
         phase_cnt      <= phase_nxt;
         bit_cnt        <= bit_nxt;
         word_cnt       <= word_nxt;
         shift_reg      <= shift_nxt;
         o_data_ready   <= (state_nxt == S_WAIT_WORD);
         o_max7219_clk  <= (state_nxt == S_CLK_HIGH);
         o_max7219_data <= din_nxt;
         o_max7219_load <= (state_nxt == S_LOAD);
         o_busy         <= (state_nxt != S_IDLE);
         o_frame_done   <= (state == S_LOAD) && (state_nxt == S_IDLE);
      end
   end

endmodule

// File: tb/tb_max7219_spi_serializer.sv
// Directed bench: default-parameter instance for full frames, stalls, ignored starts and reset;
// a minimal 1/1/1 instance for the short-frame timing case.
module tb_max7219_spi_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [15:0] i_data = '0;
   logic        i_data_valid = 1'b0;
   logic        o_data_ready, o_max7219_clk, o_max7219_data, o_max7219_load, o_busy, o_frame_done;

   logic        s_start = 1'b0;
   logic [15:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready, s_mclk, s_mdata, s_mload, s_busy, s_done;

   max7219_spi_serializer dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_data(i_data), .i_data_valid(i_data_valid),
      .o_data_ready(o_data_ready), .o_max7219_clk(o_max7219_clk), .o_max7219_data(o_max7219_data),
      .o_max7219_load(o_max7219_load), .o_busy(o_busy), .o_frame_done(o_frame_done)
   );

   max7219_spi_serializer #(.G_MATRIX_NB(1), .G_MAX_HALF_PERIOD(1), .G_LOAD_DURATION(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_data(s_data), .i_data_valid(s_valid),
      .o_data_ready(s_ready), .o_max7219_clk(s_mclk), .o_max7219_data(s_mdata),
      .o_max7219_load(s_mload), .o_busy(s_busy), .o_frame_done(s_done)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Bus monitor for the default instance, sampled on the falling system clock edge.
   int          rises = 0, nb = 0, rx_n = 0, last_rise = 0, hi_run = 0;
   int          load_run = 0, load_len = 0, load_pulses = 0, clk_in_load = 0;
   int          done_cnt = 0, period_bad = 0, hi_bad = 0, din_bad = 0, gap_bad = 0;
   logic [15:0] sh = '0;
   logic [15:0] rx_words [0:31];
   logic        p_clk = 1'b0, p_load = 1'b0, p_data = 1'b0, p_ready = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         nb = 0; hi_run = 0; load_run = 0;
         p_clk = 1'b0; p_load = 1'b0; p_data = 1'b0; p_ready = 1'b0;
      end else begin
         if (o_max7219_clk && !p_clk) begin
            if (nb != 0 && (cyc - last_rise) != 8) period_bad++;
            last_rise = cyc;
            sh = {sh[14:0], o_max7219_data};
            nb++;
            rises++;
            if (nb == 16) begin
               if (rx_n < 32) rx_words[rx_n] = sh;
               rx_n++;
               nb = 0;
            end
         end
         if (o_max7219_clk) hi_run++;
         else if (p_clk) begin
            if (hi_run != 4) hi_bad++;
            hi_run = 0;
         end
         if (o_max7219_load && o_max7219_clk) clk_in_load++;
         if (o_max7219_load) load_run++;
         else if (p_load) begin
            load_pulses++;
            load_len = load_run;
            load_run = 0;
         end
         if (o_max7219_data != p_data && !(p_clk && !o_max7219_clk) && !p_ready) din_bad++;
         if (o_frame_done) done_cnt++;
         p_clk = o_max7219_clk; p_load = o_max7219_load; p_data = o_max7219_data; p_ready = o_data_ready;
      end
   end

   int          s_rises = 0, s_nb = 0, s_last = 0, s_period_bad = 0, s_load_run = 0, s_load_len = 0, s_load_pulses = 0;
   logic [15:0] s_sh = '0, s_word = '0;
   logic        sp_clk = 1'b0, sp_load = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (s_mclk && !sp_clk) begin
            if (s_nb != 0 && (cyc - s_last) != 2) s_period_bad++;
            s_last = cyc;
            s_sh = {s_sh[14:0], s_mdata};
            s_nb++;
            s_rises++;
            if (s_nb == 16) begin
               s_word = s_sh;
               s_nb = 0;
            end
         end
         if (s_mload) s_load_run++;
         else if (sp_load) begin
            s_load_pulses++;
            s_load_len = s_load_run;
            s_load_run = 0;
         end
         sp_clk = s_mclk; sp_load = s_mload;
      end
   end

   int t0;

   task automatic clear_mon();
      rises = 0; rx_n = 0; nb = 0; load_pulses = 0; clk_in_load = 0; done_cnt = 0;
      period_bad = 0; hi_bad = 0; din_bad = 0; gap_bad = 0; load_len = 0;
   endtask

   task automatic start_frame();
      @(posedge clk); #1;
      i_start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic feed(input int n, input int gap_word, input int gap, input int pulse_word);
      for (int k = 0; k < n; k++) begin
         int w;
         i_data = 16'h0100 + 16'(k);
         if (k == gap_word) begin
            i_data_valid = 1'b0;
            w = 0;
            while (!o_data_ready && w < 2000) begin @(negedge clk); w++; end
            repeat (gap) begin
               @(posedge clk); #1;
               if (o_max7219_clk || o_max7219_load || !o_data_ready) gap_bad++;
            end
         end
         i_data_valid = 1'b1;
         w = 0;
         while (!o_data_ready && w < 2000) begin @(negedge clk); w++; end
         check($sformatf("ready_wait_w%0d", k), o_data_ready, 1);
         @(posedge clk); #1;
         if (k == pulse_word) begin
            i_start = 1'b1;
            @(posedge clk); #1;
            i_start = 1'b0;
         end
      end
      i_data_valid = 1'b0;
   endtask

   task automatic wait_done(input bit restart, output int dcyc);
      int w = 0;
      while (!o_frame_done && w < 3000) begin @(negedge clk); w++; end
      check("done_seen", o_frame_done, 1);
      dcyc = cyc;
      if (restart) begin
         i_start = 1'b1;
         @(posedge clk); #1;
         i_start = 1'b0;
      end
   endtask

   task automatic check_words(input string tag, input int n);
      check({tag, "_nwords"}, rx_n, n);
      for (int k = 0; k < n && k < 32; k++)
         check($sformatf("%s_word%0d", tag, k), rx_words[k], 16'h0100 + 16'(k));
   endtask

   initial begin
      int dc, w;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {o_data_ready, o_max7219_clk, o_max7219_data, o_max7219_load, o_busy, o_frame_done}, 0);
      check("rst_outputs_s", {s_ready, s_mclk, s_mdata, s_mload, s_busy, s_done}, 0);
      #2 rst_n = 1'b1;

      // Full frame, valid held high
      clear_mon();
      start_frame();
      check("t1_ready_t0p1", o_data_ready, 1);
      feed(8, -1, 0, -1);
      wait_done(1'b0, dc);
      check("t1_done_time", dc - t0, 1037);
      repeat (3) @(posedge clk);
      #1;
      check("t1_rises", rises, 128);
      check_words("t1", 8);
      check("t1_load_pulses", load_pulses, 1);
      check("t1_load_len", load_len, 4);
      check("t1_clk_in_load", clk_in_load, 0);
      check("t1_period", period_bad, 0);
      check("t1_high_time", hi_bad, 0);
      check("t1_din_stable", din_bad, 0);
      check("t1_din_hold", o_max7219_data, 1);
      check("t1_idle", {o_busy, o_data_ready}, 0);

      // Valid withheld 50 cycles before word 3
      clear_mon();
      start_frame();
      feed(8, 3, 50, -1);
      wait_done(1'b0, dc);
      check("t2_done_time", dc - t0, 1087);
      repeat (3) @(posedge clk);
      #1;
      check("t2_gap_quiet", gap_bad, 0);
      check_words("t2", 8);
      check("t2_load_pulses", load_pulses, 1);
      check("t2_din_stable", din_bad, 0);

      // Start pulsed mid-frame and coincident with frame_done
      clear_mon();
      start_frame();
      feed(8, -1, 0, 4);
      wait_done(1'b1, dc);
      check("t4_done_time", dc - t0, 1037);
      repeat (20) @(posedge clk);
      #1;
      check("t4_busy", o_busy, 0);
      check("t4_ready", o_data_ready, 0);
      check("t4_done_cnt", done_cnt, 1);
      check("t4_load_pulses", load_pulses, 1);
      check("t4_rises", rises, 128);

      // Asynchronous reset during CLK_HIGH of word 5
      clear_mon();
      start_frame();
      feed(6, -1, 0, -1);
      w = 0;
      while (!o_max7219_clk && w < 500) begin @(negedge clk); w++; end
      check("t5_in_clk_high", o_max7219_clk, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_outputs", {o_data_ready, o_max7219_clk, o_max7219_data, o_max7219_load, o_busy, o_frame_done}, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t5_idle_after", {o_busy, o_data_ready, o_max7219_load}, 0);
      clear_mon();
      start_frame();
      feed(8, -1, 0, -1);
      wait_done(1'b0, dc);
      check("t5_done_time", dc - t0, 1037);
      repeat (3) @(posedge clk);
      #1;
      check_words("t5", 8);
      check("t5_load_pulses", load_pulses, 1);

      // Minimal chain: 1 matrix, half period 1, load 1
      @(posedge clk); #1;
      s_start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      s_start = 1'b0;
      s_data  = 16'h0C01;
      s_valid = 1'b1;
      w = 0;
      while (!s_ready && w < 100) begin @(negedge clk); w++; end
      check("t3_ready", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      w = 0;
      while (!s_done && w < 200) begin @(negedge clk); w++; end
      check("t3_done_seen", s_done, 1);
      check("t3_done_time", cyc - t0, 35);
      repeat (3) @(posedge clk);
      #1;
      check("t3_rises", s_rises, 16);
      check("t3_word", s_word, 16'h0C01);
      check("t3_period", s_period_bad, 0);
      check("t3_load_len", s_load_len, 1);
      check("t3_load_pulses", s_load_pulses, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/max7219_spi_serializer.md
# max7219_spi_serializer

Serialises 16-bit MAX7219 command words onto the 3-wire MAX7219 bus (CLK/DIN/LOAD) for a daisy chain of G_MATRIX_NB matrices. It sits directly downstream of the UART display controller's static/scroller RAM readout logic and drives the o_max7219_* pins of the display wrapper. Upstream logic supplies one word per matrix through a valid/ready handshake. The block shifts them MSB first and closes each frame with a LOAD pulse.

## Interface
- G_MATRIX_NB, 8: words per frame (chain length); ≥1.
- G_MAX_HALF_PERIOD, 4: MAX7219 CLK half period in clk cycles; ≥1.
- G_LOAD_DURATION, 4: LOAD high time in clk cycles; ≥1.

- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle frame request; sampled only in IDLE.
- i_data  in  16  command word, [15:8] address, [7:0] data; first word accepted goes to the farthest matrix.
- i_data_valid  in  1  i_data valid.
- o_data_ready  out  1  high only in WAIT_WORD; transfer when valid&ready.
- o_max7219_clk  out  1  serial clock, idle low.
- o_max7219_data  out  1  serial data.
- o_max7219_load  out  1  latch pulse, idle low.
- o_busy  out  1  high in every state except IDLE.
- o_frame_done  out  1  one-cycle pulse after LOAD falls.

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE. Reset is asynchronous and takes effect mid-frame; there is no partial-frame recovery.
- FSM states: IDLE, WAIT_WORD, CLK_LOW, CLK_HIGH, LOAD.
- IDLE: if i_start=1 → WAIT_WORD, word_cnt=0. Otherwise stay.
- WAIT_WORD: o_data_ready=1 and o_max7219_clk=0.
  - On valid&ready: shift_reg←i_data, bit_cnt←15, o_max7219_data←i_data[15], → CLK_LOW.
  - Without valid: stay indefinitely. CLK and DIN hold their values; this is not an error.
- CLK_LOW: CLK=0 for G_MAX_HALF_PERIOD cycles, then → CLK_HIGH.
- CLK_HIGH: CLK=1 for G_MAX_HALF_PERIOD cycles. On exit:
  - If bit_cnt≠0: bit_cnt−1, DIN←next bit (MSB first), → CLK_LOW.
  - Else if word_cnt≠G_MATRIX_NB−1: word_cnt+1, → WAIT_WORD.
  - Else → LOAD.
- DIN changes only on the cycle CLK falls (CLK_HIGH→CLK_LOW/WAIT_WORD/LOAD), so it is stable for the whole high phase. The device samples on the rising edge.
- LOAD: o_max7219_load=1 for G_LOAD_DURATION cycles with CLK=0, then → IDLE. o_frame_done=1 in the first IDLE cycle.
- i_start is ignored while o_busy=1. Simultaneous i_start and o_frame_done in the same cycle: no new frame starts; i_start must be re-presented.
- DIN after LOAD: holds the last bit shifted (bit 0 of the final word). It is not cleared.
- Counter widths:
  - phase/load counter: clog2(max(G_MAX_HALF_PERIOD,G_LOAD_DURATION))+1.
  - bit_cnt: 4 bits.
  - word_cnt: clog2(G_MATRIX_NB)+1. No wrap inside a frame.

## Timing
- i_start at cycle T0 → WAIT_WORD and o_data_ready at T0+1.
- Per word: 1 handshake cycle + 32·G_MAX_HALF_PERIOD shift cycles, plus any cycles spent waiting for i_data_valid.
- Back-to-back valid: o_frame_done at T0 + 1 + G_MATRIX_NB·(1+32·G_MAX_HALF_PERIOD) + G_LOAD_DURATION. With defaults this is T0+1037.
- CLK period is exactly 2·G_MAX_HALF_PERIOD cycles at 50% duty. Exactly 16·G_MATRIX_NB rising edges occur per frame.
- LOAD rises in the cycle after the final CLK fall. No CLK edge occurs while LOAD=1.
- Earliest next frame: i_start in the o_frame_done cycle is ignored (see Operation). A new frame can start when i_start is presented in the cycle after o_frame_done.

## Test plan
- Defaults; i_start plus 8 words, valid held high, word k = 0x0100+k → 128 CLK rising edges. Data at the rising edges equals 0x0100..0x0107 MSB first. One LOAD pulse of 4 cycles. o_frame_done at T0+1037.
- i_data_valid withheld 50 cycles before word 3 → CLK stays low and LOAD stays low during the gap. Shifted bitstream unchanged. o_frame_done delayed by exactly 50 cycles.
- G_MATRIX_NB=1, G_MAX_HALF_PERIOD=1, G_LOAD_DURATION=1, word 0x0C01 → 16 CLK edges of period 2. LOAD high for 1 cycle. o_frame_done at T0+35.
- i_start pulsed during shifting, and again coincident with o_frame_done → ignored both times. Exactly one frame is sent.
- rst_n asserted during CLK_HIGH of word 5 → all outputs 0 asynchronously. After release, the FSM is IDLE and o_data_ready=0. A fresh frame then completes normally.
- Checker cross-check: each of 8 words fed through max7219_spi_checker → one frame_received per word, data_received equal to the word sent, one load_received per frame.
